// File: rtl/kmeans_sequencer.sv
// Run-level controller for the k-means datapath: centroid load, point streaming, mean
// recomputation, write-back and convergence loop. Optional macro: KMEANS_SEQ_ITER_LIMIT_EN.
module kmeans_sequencer #(
    parameter int addrWidth    = 8,
    parameter int centroid_num = 8,
    parameter int PIPE_LAT     = 2,
    parameter int ITER_W       = 8,
    parameter int MAX_ITER     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [addrWidth-1:0]    num_points,
    output logic                    ram_rd_en,
    output logic [addrWidth-1:0]    ram_addr,
    output logic                    ram_input_reg_en,
    output logic [centroid_num-1:0] centroid_en,
    output logic                    first_iteration,
    output logic                    pipe3_regs_reset_n,
    output logic                    accumulators_en,
    output logic                    means_start,
    input  logic                    means_done,
    output logic [2:0]              cent_cnt,
    output logic                    cent_wr_en,
    input  logic                    converged,
    output logic                    busy,
    output logic                    done,
    output logic [ITER_W-1:0]       iter_count,
    output logic                    iter_limit_hit
);
    typedef enum logic [3:0] {
        IDLE, LOAD, CLR, STREAM, DRAIN, MEANS, WRBACK, CHECK, FIN
    } state_t;

    localparam logic [addrWidth-1:0] LAST_CENT_ADDR = addrWidth'(centroid_num - 1);
    localparam logic [2:0]           LAST_CENT_CNT  = 3'(centroid_num - 1);

    if (PIPE_LAT < 1 || centroid_num < 1 || centroid_num > 8 || MAX_ITER < 1) begin : g_bad_cfg
        $error("kmeans_sequencer: unsupported parameter combination");
    end

    state_t                 state;
    logic [addrWidth-1:0]   num_pts;
    logic [PIPE_LAT-1:0]    acc_pipe_p;
    logic [ITER_W-1:0]      iter_next;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign iter_next       = sat_inc(iter_count);
    assign accumulators_en = acc_pipe_p[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            num_pts <= num_points;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            ram_rd_en          <= 1'b0;
            ram_addr           <= '0;
            ram_input_reg_en   <= 1'b0;
            acc_pipe_p         <= '0;
            centroid_en        <= '0;
            first_iteration    <= 1'b0;
            pipe3_regs_reset_n <= 1'b1;
            means_start        <= 1'b0;
            cent_cnt           <= '0;
            cent_wr_en         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            iter_count         <= '0;
`ifdef KMEANS_SEQ_ITER_LIMIT_EN
            iter_limit_hit     <= 1'b0;
`endif
        end else begin
            // Read-data capture and the classify-pipe delay line toward the accumulators
            ram_input_reg_en <= ram_rd_en && (state == STREAM);
            acc_pipe_p       <= (acc_pipe_p << 1) | PIPE_LAT'(ram_input_reg_en);
            centroid_en      <= (state == LOAD && ram_rd_en) ? (centroid_num'(1) << ram_addr) : '0;
            first_iteration  <= ram_rd_en && (state == LOAD);

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        ram_rd_en  <= 1'b1;
                        ram_addr   <= '0;
                        iter_count <= '0;
`ifdef KMEANS_SEQ_ITER_LIMIT_EN
                        iter_limit_hit <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (ram_rd_en) begin
                        if (ram_addr == LAST_CENT_ADDR) begin
                            ram_rd_en <= 1'b0;
                            ram_addr  <= '0;
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                        end
                    end
                    if (centroid_en[centroid_num-1]) begin
                        state              <= CLR;
                        pipe3_regs_reset_n <= 1'b0;
                    end
                end
                CLR: begin
                    pipe3_regs_reset_n <= 1'b1;
                    ram_rd_en          <= 1'b1;
                    ram_addr           <= '0;
                    state              <= STREAM;
                end
                STREAM: begin
                    if (ram_addr == num_pts) begin
                        ram_rd_en <= 1'b0;
                        ram_addr  <= '0;
                        state     <= DRAIN;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Leave right after the final accumulate, once nothing is left in flight
                    if (accumulators_en && !ram_input_reg_en && ((acc_pipe_p << 1) == '0)) begin
                        state       <= MEANS;
                        means_start <= 1'b1;
                    end
                end
                MEANS: begin
                    means_start <= 1'b0;
                    if (!means_start && means_done) begin
                        state      <= WRBACK;
                        cent_wr_en <= 1'b1;
                        cent_cnt   <= '0;
                    end
                end
                WRBACK: begin
                    if (cent_cnt == LAST_CENT_CNT) begin
                        cent_wr_en <= 1'b0;
                        cent_cnt   <= '0;
                        state      <= CHECK;
                    end else begin
                        cent_cnt <= cent_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    iter_count <= iter_next;
                    if (converged) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
`ifdef KMEANS_SEQ_ITER_LIMIT_EN
                    else if (iter_next == ITER_W'(MAX_ITER)) begin
                        state          <= FIN;
                        done           <= 1'b1;
                        iter_limit_hit <= 1'b1;
                    end
`endif
                    else begin
                        state              <= CLR;
                        pipe3_regs_reset_n <= 1'b0;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef KMEANS_SEQ_ITER_LIMIT_EN
    assign iter_limit_hit = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_sequencer.sv
// Bench for kmeans_sequencer: per-run expected-output timelines built from the run's
// phase lengths, replayed cycle by cycle against the DUT with randomized stimulus.
`timescale 1ns/1ps
module tb_kmeans_sequencer;
    localparam int AW   = 8;
    localparam int CN   = 8;
    localparam int PL   = 2;
    localparam int IW   = 8;
    localparam int MI   = 4;
    localparam int MAXC = 2048;

    logic          clk = 1'b0;
    logic          rst, start, means_done, converged;
    logic [AW-1:0] num_points;
    logic          ram_rd_en, ram_input_reg_en, first_iteration, pipe3_regs_reset_n;
    logic          accumulators_en, means_start, cent_wr_en, busy, done, iter_limit_hit;
    logic [AW-1:0] ram_addr;
    logic [CN-1:0] centroid_en;
    logic [2:0]    cent_cnt;
    logic [IW-1:0] iter_count;

    kmeans_sequencer #(.addrWidth(AW), .centroid_num(CN), .PIPE_LAT(PL), .ITER_W(IW),
                       .MAX_ITER(MI)) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_input_reg_en(ram_input_reg_en),
        .centroid_en(centroid_en), .first_iteration(first_iteration),
        .pipe3_regs_reset_n(pipe3_regs_reset_n), .accumulators_en(accumulators_en),
        .means_start(means_start), .means_done(means_done), .cent_cnt(cent_cnt),
        .cent_wr_en(cent_wr_en), .converged(converged), .busy(busy), .done(done),
        .iter_count(iter_count), .iter_limit_hit(iter_limit_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic          inen;
        logic [CN-1:0] cen;
        logic          fi;
        logic          pn;
        logic          acc;
        logic          ms;
        logic [2:0]    cc;
        logic          wr;
        logic          bsy;
        logic          dn;
        logic [IW-1:0] iter;
        logic          lim;
    } outs_t;

    outs_t         exp_o    [MAXC];
    logic          in_start [MAXC];
    logic          in_md    [MAXC];
    logic          in_conv  [MAXC];
    logic [AW-1:0] in_np    [MAXC];
    int            dsel     [16];
    int            run_len, first_ms, prev_iter;
    logic          prev_lim;
    int            n_checks = 0, n_pass = 0;
    int            cnt_in, cnt_acc, cnt_done, cnt_cen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic outs_t sample();
        outs_t a;
        a.rd = ram_rd_en;   a.addr = ram_addr;   a.inen = ram_input_reg_en;
        a.cen = centroid_en; a.fi = first_iteration; a.pn = pipe3_regs_reset_n;
        a.acc = accumulators_en; a.ms = means_start; a.cc = cent_cnt; a.wr = cent_wr_en;
        a.bsy = busy; a.dn = done; a.iter = iter_count; a.lim = iter_limit_hit;
        return a;
    endfunction

    function automatic outs_t reset_vals();
        outs_t r = '0;
        r.pn = 1'b1;
        return r;
    endfunction

    // Expected timeline of one run: cycle 0 carries the start pulse, LOAD occupies
    // CN reads, then each iteration is CLR, n+1 reads, drain, means, CN write-backs, check.
    task automatic build_run(input int n, input int conv_it, input bit abuse);
        int b, m, d, w, ch, it, endc;
        bit stop, lim;
        outs_t idle;
        idle = '0; idle.pn = 1'b1; idle.iter = IW'(prev_iter); idle.lim = prev_lim;
        for (int c = 0; c < MAXC; c++) begin
            exp_o[c] = idle;
            if (c > 0) begin exp_o[c].iter = '0; exp_o[c].lim = 1'b0; end
            in_start[c] = 1'b0; in_md[c] = 1'b0;
            in_conv[c] = 1'($urandom); in_np[c] = AW'($urandom);
        end
        in_start[0] = 1'b1; in_np[0] = AW'(n);
        for (int k = 0; k < CN; k++) begin
            exp_o[1+k].rd = 1'b1; exp_o[1+k].addr = AW'(k);
            exp_o[2+k].cen = CN'(1) << k; exp_o[2+k].fi = 1'b1;
        end
        b = CN + 2; it = 0; stop = 1'b0; lim = 1'b0; first_ms = -1; endc = 0;
        while (!stop) begin
            exp_o[b].pn = 1'b0;
            for (int k = 0; k <= n; k++) begin
                exp_o[b+1+k].rd = 1'b1; exp_o[b+1+k].addr = AW'(k);
                exp_o[b+2+k].inen = 1'b1;
                exp_o[b+2+k+PL].acc = 1'b1;
            end
            if (abuse && it == 0) in_start[b + 1 + int'($urandom_range(0, n))] = 1'b1;
            m = b + 3 + n + PL;
            exp_o[m].ms = 1'b1;
            if (first_ms < 0) first_ms = m;
            if (dsel[it] < 0) begin
                d = 1;
                for (int c = m - 2; c <= m + 1; c++) in_md[c] = 1'b1;
            end else begin
                d = (dsel[it] > 0) ? dsel[it] : int'($urandom_range(1, 6));
                in_md[m] = 1'($urandom);
                in_md[m+d] = 1'b1;
            end
            w = m + d + 1;
            for (int k = 0; k < CN; k++) begin
                exp_o[w+k].wr = 1'b1; exp_o[w+k].cc = 3'(k);
            end
            ch = w + CN;
            it++;
            in_conv[ch] = (it == conv_it);
`ifdef KMEANS_SEQ_ITER_LIMIT_EN
            lim = (it != conv_it) && (it == MI);
`endif
            for (int c = ch + 1; c < MAXC; c++) begin
                exp_o[c].iter = IW'((it > 255) ? 255 : it);
                exp_o[c].lim = lim;
            end
            if (it == conv_it || lim) begin
                stop = 1'b1; endc = ch + 1; exp_o[endc].dn = 1'b1;
            end else begin
                b = ch + 1;
            end
        end
        for (int c = 1; c <= endc; c++) exp_o[c].bsy = 1'b1;
        run_len = endc + 4;
        prev_iter = it; prev_lim = lim;
    endtask

    task automatic play(input int upto);
        outs_t a, e;
        for (int c = 0; c < upto; c++) begin
            @(posedge clk); #1;
            start = in_start[c]; num_points = in_np[c];
            means_done = in_md[c]; converged = in_conv[c];
            @(negedge clk);
            a = sample(); e = exp_o[c];
            if (!e.rd) a.addr = e.addr;
            check($sformatf("cycle%0d", c), 64'(a), 64'(e));
            cnt_in   += int'(ram_input_reg_en);
            cnt_acc  += int'(accumulators_en);
            cnt_done += int'(done);
            cnt_cen  += int'(centroid_en != '0);
        end
    endtask

    task automatic set_dsel_random();
        for (int i = 0; i < 16; i++) dsel[i] = ($urandom_range(0, 3) == 0) ? -1 : 0;
    endtask

    initial begin
        int exp_it;
        logic exp_lim;
        rst = 1'b1; start = 1'b0; means_done = 1'b0; converged = 1'b0; num_points = '0;
        prev_iter = 0; prev_lim = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(sample()), 64'(reset_vals()));
        rst = 1'b0;

        // Run A: 21 points, converges on the 3rd check, start abused during streaming
        set_dsel_random();
        dsel[0] = -1; dsel[1] = 5; dsel[2] = 0;
        build_run(20, 3, 1'b1);
        check("model_load_addr7", 64'(exp_o[8].addr), 64'd7);
        check("model_cen_first", 64'(exp_o[2].cen), 64'h01);
        check("model_cen_last", 64'(exp_o[9].cen), 64'h80);
        check("model_clr_cycle", 64'(exp_o[10].pn), 64'd0);
        check("model_acc_first", 64'({exp_o[13].acc, exp_o[14].acc}), 64'b01);
        check("model_acc_last", 64'({exp_o[34].acc, exp_o[35].acc}), 64'b10);
        check("model_means_start", 64'(first_ms), 64'd35);
        check("model_wrback_hold", 64'({exp_o[36].wr, exp_o[37].wr, exp_o[44].cc}), 64'b0_1_111);
        check("model_wrback_d5", 64'({exp_o[76].wr, exp_o[77].wr}), 64'b01);
        cnt_in = 0; cnt_acc = 0; cnt_done = 0; cnt_cen = 0;
        play(run_len);
        check("runA_input_reg_pulses", 64'(cnt_in), 64'd63);
        check("runA_acc_pulses", 64'(cnt_acc), 64'd63);
        check("runA_done_pulses", 64'(cnt_done), 64'd1);
        check("runA_centroid_loads", 64'(cnt_cen), 64'd8);
        check("runA_iter_count", 64'(iter_count), 64'd3);
        check("runA_busy_after", 64'(busy), 64'd0);

        // Run B: single point, converges on the first check
        set_dsel_random();
        build_run(0, 1, 1'b0);
        play(run_len);
        check("runB_iter_count", 64'(iter_count), 64'd1);

        // Run C: never converges before the 11th check
        set_dsel_random();
        build_run(int'($urandom_range(1, 12)), 11, 1'b0);
        play(run_len);
`ifdef KMEANS_SEQ_ITER_LIMIT_EN
        exp_it = MI; exp_lim = 1'b1;
`else
        exp_it = 11; exp_lim = 1'b0;
`endif
        check("runC_iter_count", 64'(iter_count), 64'(exp_it));
        check("runC_limit_hit", 64'(iter_limit_hit), 64'(exp_lim));

        for (int r = 0; r < 5; r++) begin
            set_dsel_random();
            build_run(int'($urandom_range(0, 40)), int'($urandom_range(1, 4)), 1'($urandom));
            play(run_len);
        end

        // Reset asserted during MEANS aborts the run with no done pulse
        set_dsel_random();
        build_run(int'($urandom_range(0, 10)), 3, 1'b0);
        play(first_ms + 1);
        #2 rst = 1'b1;
        #1 check("reset_abort_same_cycle", 64'(sample()), 64'(reset_vals()));
        means_done = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", k), 64'(sample()), 64'(reset_vals()));
        end
        rst = 1'b0;
        prev_iter = 0; prev_lim = 1'b0;

        set_dsel_random();
        build_run(5, 2, 1'b0);
        play(run_len);
        check("post_reset_iter_count", 64'(iter_count), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kmeans_sequencer.md
Name: kmeans_sequencer

Overview:
- Top-level controller for the k-means classification datapath: the 3-stage classify pipeline, the accumulators, the new-means block and the convergence check.
- Loads the initial centroids from RAM and streams every data point through the classify pipeline once per iteration.
- Triggers the mean recomputation, writes the new centroids back, and repeats until the convergence check reports convergence.
- Sits between the top-level start/done interface and the classification, new-means and convergence blocks.

Parameters:
- addrWidth, 8, RAM address width.
- centroid_num, 8, number of centroids (one-hot centroid_en width).
- PIPE_LAT, 2, cycles from ram_input_reg_en to the matching accumulate cycle.
- ITER_W, 8, iteration counter width.
- MAX_ITER, 16, iteration cap (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- num_points  in  addrWidth  index of the last point (point count = num_points+1); sampled at start
- ram_rd_en  out  1  RAM read strobe; data is valid 1 cycle later
- ram_addr  out  addrWidth  RAM read address
- ram_input_reg_en  out  1  capture RAM data into the pipe1 input register
- centroid_en  out  centroid_num  one-hot load enable for the initial centroid registers
- first_iteration  out  1  high while initial centroids are loaded from RAM
- pipe3_regs_reset_n  out  1  active-low one-cycle clear of accumulators and counters
- accumulators_en  out  1  accumulate enable for pipe3
- means_start  out  1  one-cycle pulse to the new-means block
- means_done  in  1  new-means block finished
- cent_cnt  out  3  centroid index being written back
- cent_wr_en  out  1  write new_centroid into centroid register cent_cnt
- converged  in  1  convergence-check result; valid in the CHECK state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a run
- iter_count  out  ITER_W  completed iterations in the current run
- iter_limit_hit  out  1  run ended on MAX_ITER (tied 0 without the optional feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All strobes 0, except pipe3_regs_reset_n=1.
  - ram_addr=0, cent_cnt=0, iter_count=0, iter_limit_hit=0.
  - Reset mid-run aborts immediately; no done pulse is issued.
- States: IDLE -> LOAD -> CLR -> STREAM -> DRAIN -> MEANS -> WRBACK -> CHECK -> (CLR | FIN) -> IDLE.
- IDLE:
  - start=1 latches num_points, clears iter_count and iter_limit_hit, goes to LOAD.
  - start while busy is ignored.
- LOAD:
  - ram_rd_en=1, ram_addr=0..centroid_num-1, one address per cycle.
  - One cycle after address k: centroid_en[k]=1 and first_iteration=1.
  - Exits the cycle after the last centroid_en.
- CLR:
  - Exactly 1 cycle with pipe3_regs_reset_n=0; ram_addr reset to 0.
- STREAM:
  - ram_rd_en=1, ram_addr counts 0..num_points, one per cycle.
  - ram_input_reg_en = ram_rd_en delayed 1 cycle.
  - accumulators_en = ram_input_reg_en delayed PIPE_LAT cycles (shift register).
  - After issuing address num_points, go to DRAIN.
  - num_points=0 gives a single-cycle STREAM.
- DRAIN:
  - No new reads; the delay line empties.
  - Exit the cycle after the last accumulators_en pulse. Total accumulators_en pulses per iteration = num_points+1.
- MEANS:
  - means_start=1 on the first cycle only, then wait for means_done.
  - means_done is ignored on the means_start cycle and honoured from the following cycle.
- WRBACK:
  - cent_wr_en=1 for centroid_num consecutive cycles, cent_cnt=0..centroid_num-1.
  - cent_cnt returns to 0 on exit.
- CHECK:
  - 1 cycle; iter_count increments, saturating at all-ones.
  - converged=1 -> FIN, otherwise -> CLR.
- FIN:
  - done=1 for 1 cycle, then IDLE.
- busy:
  - Registered; 1 from the cycle after start is accepted until the cycle after done.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: KMEANS_SEQ_ITER_LIMIT_EN.
- Defined:
  - In CHECK, if converged=0 and the incremented iter_count == MAX_ITER, go to FIN and set iter_limit_hit=1.
  - iter_limit_hit holds until the next accepted start or reset.
- Undefined:
  - Iterations are unbounded, iter_limit_hit is constant 0, and MAX_ITER is unused.

Test Plan:
- Load: start with num_points=20 -> ram_addr 0..7 on 8 consecutive cycles; centroid_en 8'h01..8'h80 one-hot, each 1 cycle after its address; first_iteration high for exactly those 8 cycles.
- Stream/latency: num_points=20, PIPE_LAT=2 -> 21 ram_input_reg_en pulses, each 1 cycle after ram_rd_en; 21 accumulators_en pulses, each 2 cycles after ram_input_reg_en; a single pipe3_regs_reset_n low cycle precedes the first read of the iteration.
- Handshake: hold means_done=1 from before means_start -> first means_done sampled the cycle after means_start; means_done delayed 5 cycles -> WRBACK starts the next cycle; cent_cnt 0..7 with cent_wr_en=1 for 8 cycles.
- Convergence: converged=0 on CHECKs 1 and 2, 1 on CHECK 3 -> iter_count=3, done pulses once, busy falls the following cycle.
- Abuse: start pulsed during STREAM -> ignored; rst asserted during MEANS -> all outputs at reset values the same cycle, no done; a new start after reset runs from LOAD.
- KMEANS_SEQ_ITER_LIMIT_EN with MAX_ITER=4 and converged tied 0 -> done after the 4th CHECK, iter_count=4, iter_limit_hit=1; without the macro, still running after 10 iterations.
